// File: rtl/rvv_backend_decode_sequencer_pkg.sv
// Shared definitions for the RVV backend decode sequencer.
//   - Default lane count and per-instruction uop limit.
//   - Width of the uop index driven back to the decode core.
//   - FSM state encoding (IDLE / BUSY).
//   - RVV_FORBID: SVA helper used by the backend RTL. It is only expanded
//     inside ASSERT_ON guarded regions.
`ifndef RVV_FORBID_SVH
`define RVV_FORBID_SVH
`define RVV_FORBID(clk, rst_n, cond, msg) \
  assert property (@(posedge clk) disable iff (!(rst_n)) !(cond)) else $error(msg)
`endif

package rvv_backend_decode_sequencer_pkg;

  localparam int NUM_DE_UOP       = 4;
  localparam int MAX_UOP_PER_INST = 8;
  localparam int UOP_INDEX_WIDTH  = $clog2(MAX_UOP_PER_INST);

  // Kept as plain localparam constants so older code can compare
  // against raw bit values.
  typedef logic [0:0] de_state_t;
  localparam de_state_t DE_IDLE = 1'b0;  // no instruction partially issued
  localparam de_state_t DE_BUSY = 1'b1;  // instruction partially issued

endpackage

// File: rtl/rvv_backend_decode_lane_cnt.sv
// Lane counter for the decode sequencer.
// It counts the run of valid lanes that starts at lane 0. It then clamps
// that count to the number of free uop-queue entries.
//   enable        in  : issue allowed this cycle (head valid, no flush)
//   dec_uop_valid in  : lanes produced by the decode core
//   uq_free_cnt   in  : free uop-queue entries
//   n_push        out : number of lanes to push (0 when !enable)
module rvv_backend_decode_lane_cnt #(
  parameter int NUM_DE_UOP    = 4,
  parameter int UQ_FREE_WIDTH = 4,
  parameter int CNT_WIDTH     = $clog2(NUM_DE_UOP + 1)
) (
  input  logic                     enable,
  input  logic [NUM_DE_UOP-1:0]    dec_uop_valid,
  input  logic [UQ_FREE_WIDTH-1:0] uq_free_cnt,
  output logic [CNT_WIDTH-1:0]     n_push
);

  localparam int MW = (CNT_WIDTH > UQ_FREE_WIDTH) ? CNT_WIDTH : UQ_FREE_WIDTH;

  logic [CNT_WIDTH-1:0] n_avail;
  logic                 run;
  logic [MW-1:0]        free_ext;
  logic [MW-1:0]        avail_ext;

  // Leading-ones count: the first clear bit ends the run. Any valid
  // lanes after that gap are never pushed.
  always_comb begin
    n_avail = '0;
    run     = 1'b1;
    for (int i = 0; i < NUM_DE_UOP; i++) begin
      if (run && dec_uop_valid[i]) begin
        n_avail = n_avail + CNT_WIDTH'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  assign free_ext  = MW'(uq_free_cnt);
  assign avail_ext = MW'(n_avail);

  always_comb begin
    n_push = '0;
    if (enable) begin
      n_push = (free_ext < avail_ext) ? CNT_WIDTH'(free_ext) : n_avail;
    end
  end

endmodule

// File: rtl/rvv_backend_decode_sequencer.sv
// Decode sequencer. It moves the uops of the command-queue head instruction
// into the uop queue, a group of up to NUM_DE_UOP lanes per cycle. It
// tracks how far through the instruction it has got, and it retires the
// head instruction when the last uop has been pushed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   inst_valid_cq2de    : command-queue head valid
//   pop_de2cq           : retire head instruction (done or empty)
//   dec_uop_valid/last  : per-lane decode-core output
//   uop_index_remain    : index of the next uop, fed back to the decode core
//   uq_free_cnt         : free uop-queue entries
//   uop_valid_de2uq     : per-lane push to the uop queue
//   flush               : trap flush; cancels the in-flight instruction
//   discard_err(_clr)   : sticky "instruction produced zero uops" flag
module rvv_backend_decode_sequencer #(
  parameter int NUM_DE_UOP       = rvv_backend_decode_sequencer_pkg::NUM_DE_UOP,
  parameter int MAX_UOP_PER_INST = rvv_backend_decode_sequencer_pkg::MAX_UOP_PER_INST,
  parameter int UQ_FREE_WIDTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                inst_valid_cq2de,
  output logic                                pop_de2cq,
  input  logic [NUM_DE_UOP-1:0]               dec_uop_valid,
  input  logic [NUM_DE_UOP-1:0]               dec_uop_last,
  output logic [$clog2(MAX_UOP_PER_INST)-1:0] uop_index_remain,
  input  logic [UQ_FREE_WIDTH-1:0]            uq_free_cnt,
  output logic [NUM_DE_UOP-1:0]               uop_valid_de2uq,
  input  logic                                flush,
  output logic                                discard_err,
  input  logic                                discard_err_clr
);

  import rvv_backend_decode_sequencer_pkg::*;

  localparam int IW = $clog2(MAX_UOP_PER_INST);
  localparam int CW = $clog2(NUM_DE_UOP + 1);

  logic            issue_en;
  logic [CW-1:0]   n_push;
  logic [NUM_DE_UOP-1:0] push_mask;
  logic [NUM_DE_UOP-1:0] last_hit;
  logic            done;
  logic            empty;
  logic            retire;

  de_state_t       state_reg, state_next;
  logic [IW-1:0]   index_reg, index_next;
  logic [IW-1:0]   index_base;
  logic [IW-1:0]   index_sum;
  logic            derr_reg, derr_next;

  assign issue_en = inst_valid_cq2de & ~flush;

  rvv_backend_decode_lane_cnt #(
    .NUM_DE_UOP    (NUM_DE_UOP),
    .UQ_FREE_WIDTH (UQ_FREE_WIDTH),
    .CNT_WIDTH     (CW)
  ) u_lane_cnt (
    .enable        (issue_en),
    .dec_uop_valid (dec_uop_valid),
    .uq_free_cnt   (uq_free_cnt),
    .n_push        (n_push)
  );

  // Thermometer push mask. Any last bit inside the pushed lanes completes
  // the instruction. Last bits after the first one add nothing to the OR.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DE_UOP; gi++) begin : g_lane
      assign push_mask[gi] = (CW'(gi) < n_push);
      assign last_hit[gi]  = push_mask[gi] & dec_uop_last[gi];
    end
  endgenerate

  assign done   = |last_hit;
  assign empty  = issue_en & (dec_uop_valid == '0);
  assign retire = flush | done | empty;

  // Outputs are held low while reset is asserted, whatever the inputs are.
  assign pop_de2cq       = rst_n & (done | empty);
  assign uop_valid_de2uq = rst_n ? push_mask : '0;

  // In IDLE the index is zero. Taking zero as the base there keeps the
  // sum independent of any stale register value.
  assign index_base = (state_reg == DE_BUSY) ? index_reg : '0;
  assign index_sum  = index_base + IW'(n_push);

  always_comb begin
    state_next = state_reg;
    index_next = index_base;
    if (retire) begin
      state_next = DE_IDLE;
      index_next = '0;
    end else if (n_push != '0) begin
      state_next = DE_BUSY;
      index_next = index_sum;
    end
  end

  // A new empty instruction in the same cycle as a clear keeps the flag set.
  always_comb begin
    derr_next = derr_reg;
    if (empty) begin
      derr_next = 1'b1;
    end else if (discard_err_clr) begin
      derr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DE_IDLE;
      index_reg <= '0;
      derr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      derr_reg  <= derr_next;
    end
  end

  assign uop_index_remain = index_reg;
  assign discard_err      = derr_reg;

`ifdef ASSERT_ON
  `RVV_FORBID(clk, rst_n,
    !retire && (n_push != '0) &&
    (({1'b0, index_base} + (IW+1)'(n_push)) >= (IW+1)'(MAX_UOP_PER_INST)),
    "uop index overflow");
  `RVV_FORBID(clk, rst_n,
    (dec_uop_valid & (dec_uop_valid + NUM_DE_UOP'(1))) != '0,
    "non-contiguous dec_uop_valid");
`endif

endmodule

// File: tb/tb_rvv_backend_decode_sequencer.sv
module tb_rvv_backend_decode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       inst_valid_cq2de;
  logic       pop_de2cq;
  logic [3:0] dec_uop_valid;
  logic [3:0] dec_uop_last;
  logic [2:0] uop_index_remain;
  logic [3:0] uq_free_cnt;
  logic [3:0] uop_valid_de2uq;
  logic       flush;
  logic       discard_err;
  logic       discard_err_clr;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    string      tag;
    logic [3:0] push;
    logic       pop;
    logic [2:0] idx;
    logic       derr;
  } exp_t;

  exp_t sb[$];

  rvv_backend_decode_sequencer #(
    .NUM_DE_UOP       (4),
    .MAX_UOP_PER_INST (8),
    .UQ_FREE_WIDTH    (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_valid_cq2de (inst_valid_cq2de),
    .pop_de2cq        (pop_de2cq),
    .dec_uop_valid    (dec_uop_valid),
    .dec_uop_last     (dec_uop_last),
    .uop_index_remain (uop_index_remain),
    .uq_free_cnt      (uq_free_cnt),
    .uop_valid_de2uq  (uop_valid_de2uq),
    .flush            (flush),
    .discard_err      (discard_err),
    .discard_err_clr  (discard_err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_total++;
    assert (obs === expv) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic exp_t take(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      e = '{tag, 4'hx, 1'bx, 3'hx, 1'bx};
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  // Starts on a falling edge. It checks the combinational outputs 1 time
  // unit later and the registered outputs 1 time unit after the next
  // rising edge.
  task automatic step(input string tag, input logic iv, input logic fl, input logic clr,
                      input logic [3:0] v, input logic [3:0] l, input logic [3:0] fr,
                      input logic [3:0] ep, input logic epop,
                      input logic [2:0] eidx, input logic ederr);
    exp_t e;
    inst_valid_cq2de = iv;
    flush            = fl;
    discard_err_clr  = clr;
    dec_uop_valid    = v;
    dec_uop_last     = l;
    uq_free_cnt      = fr;
    sb.push_back('{tag, ep, epop, eidx, ederr});
    #1;
    e = take(tag);
    chk({e.tag, ".push"}, 32'(uop_valid_de2uq), 32'(e.push));
    chk({e.tag, ".pop"},  32'(pop_de2cq),       32'(e.pop));
    @(posedge clk);
    #1;
    chk({e.tag, ".idx"},  32'(uop_index_remain), 32'(e.idx));
    chk({e.tag, ".derr"}, 32'(discard_err),      32'(e.derr));
    $display("step %s push=%b pop=%b idx=%0d derr=%b",
             e.tag, uop_valid_de2uq, pop_de2cq, uop_index_remain, discard_err);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    // Reset is asserted while busy inputs are driven. All outputs must be 0.
    rst_n            = 1'b0;
    inst_valid_cq2de = 1'b1;
    flush            = 1'b0;
    discard_err_clr  = 1'b0;
    dec_uop_valid    = 4'b1111;
    dec_uop_last     = 4'b1000;
    uq_free_cnt      = 4'd8;
    sb.push_back('{"reset", 4'b0000, 1'b0, 3'd0, 1'b0});
    #2;
    e = take("reset");
    chk({e.tag, ".push"}, 32'(uop_valid_de2uq),  32'(e.push));
    chk({e.tag, ".pop"},  32'(pop_de2cq),        32'(e.pop));
    chk({e.tag, ".idx"},  32'(uop_index_remain), 32'(e.idx));
    chk({e.tag, ".derr"}, 32'(discard_err),      32'(e.derr));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //    tag          iv   fl   clr  valid    last     free   push     pop  idx   derr
    step("single3",   1'b1,1'b0,1'b0,4'b0111,4'b0100,4'd8,  4'b0111,1'b1,3'd0,1'b0);
    step("eight_c1",  1'b1,1'b0,1'b0,4'b1111,4'b0000,4'd8,  4'b1111,1'b0,3'd4,1'b0);
    step("eight_c2",  1'b1,1'b0,1'b0,4'b1111,4'b1000,4'd8,  4'b1111,1'b1,3'd0,1'b0);
    step("bp_free2",  1'b1,1'b0,1'b0,4'b1111,4'b1000,4'd2,  4'b0011,1'b0,3'd2,1'b0);
    step("bp_free0",  1'b1,1'b0,1'b0,4'b1111,4'b1000,4'd0,  4'b0000,1'b0,3'd2,1'b0);
    step("cap_avail", 1'b1,1'b0,1'b0,4'b0011,4'b0010,4'd15, 4'b0011,1'b1,3'd0,1'b0);
    step("pre_flush", 1'b1,1'b0,1'b0,4'b1111,4'b0000,4'd8,  4'b1111,1'b0,3'd4,1'b0);
    step("flush",     1'b1,1'b1,1'b0,4'b1111,4'b1000,4'd8,  4'b0000,1'b0,3'd0,1'b0);
    step("empty",     1'b1,1'b0,1'b0,4'b0000,4'b0000,4'd8,  4'b0000,1'b1,3'd0,1'b1);
    step("empty_clr", 1'b1,1'b0,1'b1,4'b0000,4'b0000,4'd8,  4'b0000,1'b1,3'd0,1'b1);
    step("clr",       1'b1,1'b0,1'b1,4'b0111,4'b0100,4'd8,  4'b0111,1'b1,3'd0,1'b0);
    step("no_inst",   1'b0,1'b0,1'b0,4'b1111,4'b1000,4'd8,  4'b0000,1'b0,3'd0,1'b0);
    step("one_lane",  1'b1,1'b0,1'b0,4'b0001,4'b0000,4'd8,  4'b0001,1'b0,3'd1,1'b0);
    step("two_done",  1'b1,1'b0,1'b0,4'b0011,4'b0010,4'd8,  4'b0011,1'b1,3'd0,1'b0);
    step("flush_emp", 1'b0,1'b1,1'b0,4'b0000,4'b0000,4'd8,  4'b0000,1'b0,3'd0,1'b0);
    step("empty2",    1'b1,1'b0,1'b0,4'b0000,4'b0000,4'd8,  4'b0000,1'b1,3'd0,1'b1);
    step("pre_rst",   1'b1,1'b0,1'b0,4'b1111,4'b0000,4'd8,  4'b1111,1'b0,3'd4,1'b1);

    // Reset asserted part-way through a cycle while the index is 4.
    inst_valid_cq2de = 1'b1;
    dec_uop_valid    = 4'b1111;
    dec_uop_last     = 4'b1000;
    uq_free_cnt      = 4'd8;
    sb.push_back('{"mid_rst", 4'b0000, 1'b0, 3'd0, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    e = take("mid_rst");
    chk({e.tag, ".push"}, 32'(uop_valid_de2uq),  32'(e.push));
    chk({e.tag, ".pop"},  32'(pop_de2cq),        32'(e.pop));
    chk({e.tag, ".idx"},  32'(uop_index_remain), 32'(e.idx));
    chk({e.tag, ".derr"}, 32'(discard_err),      32'(e.derr));
    $display("step %s push=%b pop=%b idx=%0d derr=%b",
             e.tag, uop_valid_de2uq, pop_de2cq, uop_index_remain, discard_err);
    @(negedge clk);
    rst_n = 1'b1;

    step("post_c1",   1'b1,1'b0,1'b0,4'b1111,4'b0000,4'd8,  4'b1111,1'b0,3'd4,1'b0);
    step("post_c2",   1'b1,1'b0,1'b0,4'b1111,4'b1000,4'd8,  4'b1111,1'b1,3'd0,1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
